// File: rtl/centroid_coordinate_divider.sv
// Sequential restoring divider: seven accumulated coordinate sums / point count, one bit per cycle.
// Define CENTROID_DIV_ROUND_NEAREST_EN to round each quotient to nearest (saturating) instead of floor.
module centroid_coordinate_divider #(
  parameter int unsigned accum_cord_width = 22,
  parameter int unsigned accum_width      = 7 * 22,
  parameter int unsigned count_width      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [accum_width-1:0]      accum_in,
  input  logic [count_width-1:0]      count_in,
  output logic                        busy,
  output logic                        done,
  output logic                        div_by_zero,
  output logic [accum_cord_width-1:0] result_cord_1,
  output logic [accum_cord_width-1:0] result_cord_2,
  output logic [accum_cord_width-1:0] result_cord_3,
  output logic [accum_cord_width-1:0] result_cord_4,
  output logic [accum_cord_width-1:0] result_cord_5,
  output logic [accum_cord_width-1:0] result_cord_6,
  output logic [accum_cord_width-1:0] result_cord_7
);

  localparam int unsigned NumCord = 7;
  localparam int unsigned BitW    = $clog2(accum_cord_width);
  localparam int unsigned RemW    = count_width + 1;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e                      state_q, state_d;
  logic [accum_width-1:0]      accum_q;
  logic [count_width-1:0]      count_q;
  logic [RemW-1:0]             rem_q;
  logic [accum_cord_width-1:0] quot_q;
  logic [BitW-1:0]             bit_q;
  logic [2:0]                  idx_q;
  logic [accum_cord_width-1:0] result_q [NumCord];

  logic [accum_cord_width-1:0] cur_cord;
  logic                        cur_bit;
  logic [RemW-1:0]             rem_shift;
  logic                        rem_ge;
  logic [RemW-1:0]             rem_sub;
  logic [accum_cord_width-1:0] quot_next;
  logic [accum_cord_width-1:0] quot_final;
  logic                        last_bit;
  logic                        last_cord;

  // The current coordinate always sits in the low slice; accum_q shifts down per coordinate.
  always_comb begin
    cur_cord  = accum_q[accum_cord_width-1:0];
    cur_bit   = cur_cord[BitW'(accum_cord_width - 1) - bit_q];
    rem_shift = {rem_q[count_width-1:0], cur_bit};
    rem_ge    = rem_shift >= {1'b0, count_q};
    rem_sub   = rem_ge ? (rem_shift - {1'b0, count_q}) : rem_shift;
    quot_next = {quot_q[accum_cord_width-2:0], rem_ge};
    last_bit  = (bit_q == BitW'(accum_cord_width - 1));
    last_cord = (idx_q == 3'(NumCord - 1));
  end

`ifdef CENTROID_DIV_ROUND_NEAREST_EN
  always_comb begin
    quot_final = quot_next;
    if (({rem_sub, 1'b0} >= {2'b00, count_q}) && !(&quot_next)) begin
      quot_final = quot_next + accum_cord_width'(1);
    end
  end
`else
  always_comb begin
    quot_final = quot_next;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (count_in == '0) ? StDone : StDiv;
      end
      StDiv: begin
        if (last_bit && last_cord) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      accum_q <= '0;
      count_q <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < NumCord; k++) result_q[k] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            accum_q <= accum_in;
            count_q <= count_in;
            rem_q   <= '0;
            quot_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
          end
        end
        StDiv: begin
          if (last_bit) begin
            for (int k = 0; k < NumCord; k++) begin
              if (idx_q == 3'(k)) result_q[k] <= quot_final;
            end
            accum_q <= accum_q >> accum_cord_width;
            rem_q   <= '0;
            quot_q  <= '0;
            bit_q   <= '0;
            idx_q   <= idx_q + 3'd1;
          end else begin
            rem_q  <= rem_sub;
            quot_q <= quot_next;
            bit_q  <= bit_q + BitW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign div_by_zero   = (state_q == StDone) && (count_q == '0);
  assign result_cord_1 = result_q[0];
  assign result_cord_2 = result_q[1];
  assign result_cord_3 = result_q[2];
  assign result_cord_4 = result_q[3];
  assign result_cord_5 = result_q[4];
  assign result_cord_6 = result_q[5];
  assign result_cord_7 = result_q[6];

endmodule
